// File: rtl/adc_capture.sv
// ADC front end: conversion clock divider, pipeline discard, one-entry output register.
// Define ADC_CAPTURE_OTR_SAT_EN to saturate out-of-range samples.
module adc_capture #(
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 8,
    parameter int PIPE_DLY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_otr,
    output logic              ad_clk,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_otr,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int DC_W = (PIPE_DLY < 1) ? 1 : $clog2(PIPE_DLY + 1);
    localparam logic [DIV_W-1:0] D_MIN = DIV_W'(2);
    localparam logic [DC_W-1:0]  DISC_N = DC_W'(PIPE_DLY);

    logic              en_q;
    logic [DIV_W-1:0]  cnt, cnt_n;
    logic [DIV_W-1:0]  d, d_n;
    logic [DIV_W-1:0]  div_sat;
    logic              ad_clk_n;
    logic [DC_W-1:0]   disc, disc_n;
    logic              en_rise;
    logic              wrap;
    logic              capture;
    logic              deliver;
    logic              can_load;
    logic              xfer;
    logic [DATA_W-1:0] cap_data;

    assign div_sat = (div < D_MIN) ? D_MIN : div;
    assign en_rise = en & ~en_q;
    assign wrap    = (cnt == d - DIV_W'(1));

    always_comb begin
        cnt_n = cnt;
        d_n   = d;
        if (!en) begin
            cnt_n = '0;
        end else if (en_rise || wrap) begin
            cnt_n = '0;
            d_n   = div_sat;
        end else begin
            cnt_n = cnt + DIV_W'(1);
        end
    end

    // ad_clk is registered from next-cycle counter state so it tracks cnt exactly
    assign ad_clk_n = en & (cnt_n < (d_n >> 1));

    assign capture  = en & en_q & (cnt == (d >> 1));
    assign deliver  = capture & (disc == DISC_N);
    assign xfer     = sample_valid & sample_ready;
    assign can_load = ~sample_valid | sample_ready;

    always_comb begin
        disc_n = disc;
        if (!en || en_rise) begin
            disc_n = '0;
        end else if (capture && disc != DISC_N) begin
            disc_n = disc + DC_W'(1);
        end
    end

`ifdef ADC_CAPTURE_OTR_SAT_EN
    assign cap_data = ad_otr ? {DATA_W{ad_data[DATA_W-1]}} : ad_data;
`else
    assign cap_data = ad_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            cnt    <= '0;
            d      <= D_MIN;
            ad_clk <= 1'b0;
            disc   <= '0;
        end else begin
            en_q   <= en;
            cnt    <= cnt_n;
            d      <= d_n;
            ad_clk <= ad_clk_n;
            disc   <= disc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data  <= '0;
            sample_otr   <= 1'b0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (deliver && can_load) begin
                sample_data  <= cap_data;
                sample_otr   <= ad_otr;
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            if (en_rise) begin
                overrun <= 1'b0;
            end else if (deliver && !can_load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: divider table, ramp scoreboard,
// backpressure, simultaneous capture/consume, OTR, reset and enable corners.
module tb_adc_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic [7:0] ad_data;
    logic       ad_otr;
    logic       ad_clk;
    logic [7:0] sample_data;
    logic       sample_otr;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;

    adc_capture #(.DATA_W(8), .DIV_W(8), .PIPE_DLY(3)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div),
        .ad_data(ad_data), .ad_otr(ad_otr), .ad_clk(ad_clk),
        .sample_data(sample_data), .sample_otr(sample_otr),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k = 0;
    bit prev_clk = 0;
    bit rose = 0;
    int rise_cyc = 0;
    int q[$];

    typedef struct { logic [7:0] dv; int hi; int lo; } div_vec_t;
    typedef struct { logic [7:0] data; logic otr; logic [7:0] exp; } otr_vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ramp ad_data by one at each conversion start (ad_clk rising)
    task automatic rstep();
        step();
        rose = ad_clk && !prev_clk;
        if (rose) begin
            ad_data  = 8'(k);
            rise_cyc = cyc;
            k++;
        end
        prev_clk = ad_clk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        sample_ready = 1'b0;
        ad_otr = 1'b0;
        ad_data = 8'h00;
        step();
        step();
        rst = 1'b0;
        k = 0;
        prev_clk = 0;
    endtask

    task automatic wait_valid(input int lim, input bit ramp);
        int n = 0;
        while (!sample_valid && n < lim) begin
            if (ramp) rstep(); else step();
            n++;
        end
        chk("wait_valid", 32'(sample_valid), 1);
    endtask

    task automatic run_ramp(input logic [7:0] dv, input int ncyc,
                            input bit mode);
        int d;
        int last_pop = -1;
        int pops = 0;
        int gaps = 0;
        bit seen = 0;
        bit first = 1;
        d = (dv < 2) ? 2 : int'(dv);
        do_reset();
        div = dv;
        sample_ready = !mode;
        q.delete();
        en = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            rstep();
            if (rose && k - 1 >= 3) q.push_back(k - 1);
            if (mode) sample_ready = !ad_clk;
            if (mode && seen && !sample_valid) gaps++;
            if (sample_valid) seen = 1;
            if (sample_valid && sample_ready) begin
                if (q.size() == 0) begin
                    chk("ramp_unexpected", 32'(sample_data), 32'hFFFF);
                end else begin
                    chk("ramp_data", 32'(sample_data), 32'(q.pop_front()));
                end
                if (first) chk("ramp_first", 32'(sample_data), 3);
                first = 0;
                if (!mode) begin
                    chk("ramp_latency", 32'(cyc - rise_cyc), 32'((d >> 1) + 1));
                    if (last_pop >= 0)
                        chk("ramp_interval", 32'(cyc - last_pop), 32'(d));
                end
                last_pop = cyc;
                pops++;
            end
        end
        chk("ramp_overrun", 32'(overrun), 0);
        chk("ramp_pops_min", 32'(pops >= (ncyc / d) - 5), 1);
        if (mode) chk("ramp_gaps", 32'(gaps), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        div_vec_t dvt[6];
        otr_vec_t ovt[3];
        int bad;
        logic [7:0] exp_next;

        dvt[0] = '{8'd8, 4, 4};
        dvt[1] = '{8'd5, 2, 3};
        dvt[2] = '{8'd0, 1, 1};
        dvt[3] = '{8'd1, 1, 1};
        dvt[4] = '{8'd2, 1, 1};
        dvt[5] = '{8'd7, 3, 4};
`ifdef ADC_CAPTURE_OTR_SAT_EN
        ovt[0] = '{8'hC3, 1'b1, 8'hFF};
        ovt[1] = '{8'h43, 1'b1, 8'h00};
`else
        ovt[0] = '{8'hC3, 1'b1, 8'hC3};
        ovt[1] = '{8'h43, 1'b1, 8'h43};
`endif
        ovt[2] = '{8'hC3, 1'b0, 8'hC3};

        div = 8'd8;
        do_reset();
        chk("rst_ad_clk", 32'(ad_clk), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_data", 32'(sample_data), 0);
        chk("rst_otr", 32'(sample_otr), 0);
        chk("rst_overrun", 32'(overrun), 0);

        foreach (dvt[i]) begin
            int per;
            per = dvt[i].hi + dvt[i].lo;
            en = 1'b0;
            div = dvt[i].dv;
            step();
            step();
            en = 1'b1;
            step();
            chk("div_start_high", 32'(ad_clk), 1);
            bad = 0;
            for (int j = 0; j < 3 * per; j++) begin
                if (ad_clk !== ((j % per) < dvt[i].hi)) bad++;
                step();
            end
            chk("div_pattern", 32'(bad), 0);
        end

        // Mid-period divisor change waits for the next period
        en = 1'b0;
        div = 8'd8;
        step();
        en = 1'b1;
        step();
        step();
        div = 8'd4;
        bad = 0;
        for (int j = 1; j < 8 + 12; j++) begin
            if (j < 8) begin
                if (ad_clk !== (j < 4)) bad++;
            end else begin
                if (ad_clk !== (((j - 8) % 4) < 2)) bad++;
            end
            step();
        end
        chk("div_change", 32'(bad), 0);

        run_ramp(8'd8, 120, 1'b0);
        run_ramp(8'd2, 40, 1'b1);

        // Backpressure: hold first sample, drop the next ones
        do_reset();
        div = 8'd8;
        en = 1'b1;
        wait_valid(200, 1'b1);
        chk("bp_first", 32'(sample_data), 3);
        bad = 0;
        for (int n = 0; n < 200 && bad < 3; n++) begin
            rstep();
            if (rose) bad++;
        end
        chk("bp_hold", 32'(sample_data), 3);
        chk("bp_overrun", 32'(overrun), 1);
        exp_next = 8'(k - 1);
        sample_ready = 1'b1;
        rstep();
        chk("bp_consumed", 32'(sample_valid), 0);
        wait_valid(20, 1'b1);
        chk("bp_next", 32'(sample_data), 32'(exp_next));
        en = 1'b0;
        step();
        step();
        chk("bp_overrun_sticky", 32'(overrun), 1);
        en = 1'b1;
        step();
        chk("bp_overrun_clr", 32'(overrun), 0);

        foreach (ovt[i]) begin
            do_reset();
            div = 8'd4;
            ad_data = ovt[i].data;
            ad_otr = ovt[i].otr;
            sample_ready = 1'b1;
            en = 1'b1;
            wait_valid(100, 1'b0);
            chk("otr_data", 32'(sample_data), 32'(ovt[i].exp));
            chk("otr_flag", 32'(sample_otr), 32'(ovt[i].otr));
        end

        // Reset with a pending sample
        do_reset();
        div = 8'd4;
        ad_data = 8'h5A;
        ad_otr = 1'b1;
        en = 1'b1;
        wait_valid(100, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(sample_valid), 0);
        chk("mid_rst_data", 32'(sample_data), 0);
        chk("mid_rst_otr", 32'(sample_otr), 0);
        chk("mid_rst_ad_clk", 32'(ad_clk), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);

        // Enable drop keeps a pending sample until consumed
        en = 1'b1;
        wait_valid(100, 1'b0);
        en = 1'b0;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (sample_valid !== 1'b1 || ad_clk !== 1'b0) bad++;
        end
        chk("en_drop_hold", 32'(bad), 0);
        chk("en_drop_data", 32'(sample_data), 32'h5A);
        sample_ready = 1'b1;
        step();
        chk("en_drop_consume", 32'(sample_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
